// File: rtl/tt_sweep.sv
// Truth-table sweeper: steps a 3-input logic block through all eight input
// vectors, captures its output for each one and compares the code to EXPECTED.
module tt_sweep #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [7:0]  EXPECTED      = 8'h74
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       out_sample,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  // "table" is a reserved word, so the captured code is exposed as truth_table
  output logic [7:0] truth_table,
  output logic       match
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("tt_sweep: SETTLE_CYCLES must be in 1..255");
  end

  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] idx;
  logic [7:0] cnt;
  logic [1:0] rst_pipe;
  logic       run;
  logic [7:0] table_cap;

  // Reset asserts asynchronously; the FSM is frozen until release has been
  // seen through two flops, so the first edges after release change nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_pipe <= 2'b00;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  assign run = rst_pipe[1];

  // Vector idx lands in bit 7-idx, so vector 000 is the code's MSB.
  always_comb begin
    table_cap = truth_table;
    table_cap[3'd7 - idx] = out_sample;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= 3'd0;
      cnt         <= 8'd0;
      in1         <= 1'b0;
      in2         <= 1'b0;
      in3         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      truth_table <= 8'h00;
      match       <= 1'b0;
    end else if (run) begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            state           <= DRIVE;
            idx             <= 3'd0;
            cnt             <= 8'd0;
            truth_table     <= 8'h00;
            match           <= 1'b0;
            busy            <= 1'b1;
            {in1, in2, in3} <= 3'b000;
          end
        end
        DRIVE: begin
          if (abort) begin
            state           <= IDLE;
            idx             <= 3'd0;
            cnt             <= 8'd0;
            busy            <= 1'b0;
            match           <= 1'b0;
            {in1, in2, in3} <= 3'b000;
          end else if (cnt == CNT_LAST) begin
            truth_table <= table_cap;
            cnt         <= 8'd0;
            if (idx == 3'd7) begin
              state           <= FINISH;
              idx             <= 3'd0;
              busy            <= 1'b0;
              done            <= 1'b1;
              match           <= (table_cap == EXPECTED);
              {in1, in2, in3} <= 3'b000;
            end else begin
              idx             <= idx + 3'd1;
              {in1, in2, in3} <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep.sv
// Randomised bench for tt_sweep: a behavioural 3-input block returns bit
// 7-v of a chosen code for vector v; a full sweep must reproduce that code.
module tb_tt_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_s, abort_s, start_f, abort_f;
  logic [7:0] code_s, code_f;
  logic       out_s, out_f;
  logic       in1_s, in2_s, in3_s, busy_s, done_s, match_s;
  logic       in1_f, in2_f, in3_f, busy_f, done_f, match_f;
  logic [7:0] tbl_s, tbl_f;

  int n_chk = 0;
  int n_bad = 0;

  assign out_s = code_s[3'd7 - {in1_s, in2_s, in3_s}];
  assign out_f = code_f[3'd7 - {in1_f, in2_f, in3_f}];

  tt_sweep #(.SETTLE_CYCLES(4), .EXPECTED(8'h74)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_s), .abort(abort_s),
    .out_sample(out_s), .in1(in1_s), .in2(in2_s), .in3(in3_s),
    .busy(busy_s), .done(done_s), .truth_table(tbl_s), .match(match_s)
  );

  tt_sweep #(.SETTLE_CYCLES(1), .EXPECTED(8'h74)) u_fast (
    .clk(clk), .rst_n(rst_n), .start(start_f), .abort(abort_f),
    .out_sample(out_f), .in1(in1_f), .in2(in2_f), .in3(in3_f),
    .busy(busy_f), .done(done_f), .truth_table(tbl_f), .match(match_f)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] vec_of(input bit sel);
    return sel ? {in1_f, in2_f, in3_f} : {in1_s, in2_s, in3_s};
  endfunction
  function automatic logic busy_of(input bit sel);
    return sel ? busy_f : busy_s;
  endfunction
  function automatic logic done_of(input bit sel);
    return sel ? done_f : done_s;
  endfunction
  function automatic logic match_of(input bit sel);
    return sel ? match_f : match_s;
  endfunction
  function automatic logic [7:0] tbl_of(input bit sel);
    return sel ? tbl_f : tbl_s;
  endfunction

  task automatic set_start(input bit sel, input logic v);
    if (sel) start_f = v;
    else start_s = v;
  endtask

  // Full sweep: busy length, vector order, single done pulse, code and match.
  task automatic run_sweep(input bit sel, input logic [7:0] code, input bit poke_start);
    int         settle = sel ? 1 : 4;
    logic [2:0] seen[$];
    int         cycles = 0;
    int         bad_vec = 0;
    int         dones = 0;
    if (sel) code_f = code;
    else code_s = code;
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    while (busy_of(sel) && cycles < 8 * settle + 8) begin
      seen.push_back(vec_of(sel));
      if (done_of(sel)) dones++;
      cycles++;
      if (poke_start) set_start(sel, 1'($urandom_range(0, 1)));
      @(negedge clk);
    end
    set_start(sel, 1'b0);
    check("busy_len", cycles, 8 * settle);
    for (int i = 0; i < seen.size(); i++)
      if (seen[i] !== 3'(i / settle)) bad_vec++;
    check("vec_seq", bad_vec, 0);
    check("done_early", dones, 0);
    check("done_pulse", done_of(sel), 1'b1);
    check("vec_finish", vec_of(sel), 3'b000);
    check("table", tbl_of(sel), code);
    check("match", match_of(sel), code == 8'h74);
    @(negedge clk);
    check("done_clr", done_of(sel), 1'b0);
    check("table_hold", tbl_of(sel), code);
    check("match_hold", match_of(sel), code == 8'h74);
  endtask

  // Abort k cycles after start acceptance: floor(k/4) vectors captured.
  task automatic abort_sweep(input logic [7:0] code, input int k);
    int         n = k / 4;
    logic [7:0] ones = 8'hFF;
    logic [7:0] mask;
    int         dones = 0;
    mask = ~(ones >> n);
    code_s = code;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    repeat (k) begin
      if (done_s) dones++;
      @(negedge clk);
    end
    abort_s = 1'b1;
    @(negedge clk);
    abort_s = 1'b0;
    check("abort_busy", busy_s, 1'b0);
    check("abort_vec", vec_of(0), 3'b000);
    check("abort_table", tbl_s, code & mask);
    check("abort_match", match_s, 1'b0);
    repeat (4) begin
      if (done_s || busy_s) dones++;
      @(negedge clk);
    end
    check("abort_nodone", dones, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         n;
    logic [7:0] saved;
    rst_n = 1'b0;
    start_s = 1'b0; abort_s = 1'b0; start_f = 1'b0; abort_f = 1'b0;
    code_s = 8'h74; code_f = 8'h74;
    repeat (2) @(negedge clk);
    check("rst_busy", busy_s, 1'b0);
    check("rst_done", done_s, 1'b0);
    check("rst_table", tbl_s, 8'h00);
    check("rst_match", match_s, 1'b0);
    check("rst_vec", vec_of(0), 3'b000);

    rst_n = 1'b1;
    start_s = 1'b1;
    @(negedge clk);
    check("sync_release", busy_s, 1'b0);
    start_s = 1'b0;
    repeat (3) @(negedge clk);

    run_sweep(0, 8'h74, 1'b0);
    run_sweep(0, 8'hFF, 1'b0);
    run_sweep(0, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) run_sweep(0, 8'($urandom), 1'($urandom_range(0, 1)));
    run_sweep(0, 8'h74, 1'b1);

    run_sweep(1, 8'h74, 1'b0);
    for (int i = 0; i < 4; i++) run_sweep(1, 8'($urandom), 1'b0);

    abort_sweep(8'h74, 12);
    for (int i = 0; i < 5; i++) abort_sweep(8'($urandom), int'($urandom_range(0, 31)));

    // start and abort together in IDLE must not start a sweep
    run_sweep(0, 8'h74, 1'b0);
    start_s = 1'b1;
    abort_s = 1'b1;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy_s) n++;
    end
    start_s = 1'b0;
    abort_s = 1'b0;
    check("start_abort_idle", n, 0);
    check("start_abort_table", tbl_s, 8'h74);
    check("start_abort_match", match_s, 1'b1);

    // start held high restarts as soon as IDLE is reached again
    code_s = 8'($urandom) | 8'h01;
    saved = code_s;
    start_s = 1'b1;
    n = 0;
    @(negedge clk);
    while (!done_s && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("held_done", done_s, 1'b1);
    check("held_table", tbl_s, saved);
    @(negedge clk);
    check("held_idle", busy_s, 1'b0);
    @(negedge clk);
    check("held_restart", busy_s, 1'b1);
    check("held_clear", tbl_s, 8'h00);
    start_s = 1'b0;
    abort_s = 1'b1;
    @(negedge clk);
    abort_s = 1'b0;
    @(negedge clk);

    // reset during vector 101 discards the sweep
    code_s = 8'h74;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    n = 0;
    while (vec_of(0) != 3'b101 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("reach_101", vec_of(0), 3'b101);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy_s, 1'b0);
    check("mid_rst_vec", vec_of(0), 3'b000);
    check("mid_rst_table", tbl_s, 8'h00);
    check("mid_rst_done", done_s, 1'b0);
    check("mid_rst_match", match_s, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_idle", busy_s, 1'b0);
    run_sweep(0, 8'h74, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
